// File: rtl/seg_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus and publishes whole frames.
// Latency: slot update 2+STABLE_CYCLES edges after a pin change; frame one edge after the mask fills.
// Backpressure: frame held until frame_ready; a frame completing while one is held is dropped with overrun.
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a,
    input  logic                    b,
    input  logic                    c,
    input  logic                    d,
    input  logic                    e,
    input  logic                    f,
    input  logic                    g,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic                    cap;
    logic [1:0]              rst_sync;
    logic                    rst_i_n;
    logic [6:0]              seg_s1, seg_s2, seg_prev;
    logic [NUM_DIGITS-1:0]   en_s1, en_s2, en_prev;
    logic                    onehot, changed;
    logic [3:0]              code;
    logic                    code_err;
    logic [4*NUM_DIGITS-1:0] slot_dig;
    logic [NUM_DIGITS-1:0]   slot_err;
    logic [NUM_DIGITS-1:0]   captured;
    logic [NUM_DIGITS-1:0]   cap_mask;

    // Reset asserts immediately, releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            seg_prev <= '0;
            en_s1    <= '0;
            en_s2    <= '0;
            en_prev  <= '0;
        end else begin
            seg_s1   <= {a, b, c, d, e, f, g};
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            en_s1    <= dig_en;
            en_s2    <= en_s1;
            en_prev  <= en_s2;
        end
    end

    assign onehot  = (en_s2 != '0) && ((en_s2 & (en_s2 - 1'b1)) == '0);
    assign changed = (seg_s2 != seg_prev) || (en_s2 != en_prev);

    always_comb begin
        code     = 4'hE;
        code_err = 1'b1;
        case (seg_s2)
            7'b1111110: begin code = 4'd0; code_err = 1'b0; end
            7'b0110000: begin code = 4'd1; code_err = 1'b0; end
            7'b1101101: begin code = 4'd2; code_err = 1'b0; end
            7'b1111001: begin code = 4'd3; code_err = 1'b0; end
            7'b0110011: begin code = 4'd4; code_err = 1'b0; end
            7'b1011011: begin code = 4'd5; code_err = 1'b0; end
            7'b1011111: begin code = 4'd6; code_err = 1'b0; end
            7'b1110000: begin code = 4'd7; code_err = 1'b0; end
            7'b1111111: begin code = 4'd8; code_err = 1'b0; end
            7'b1111011: begin code = 4'd9; code_err = 1'b0; end
            7'b0000000: begin code = 4'hF; code_err = 1'b0; end
            default:    begin code = 4'hE; code_err = 1'b1; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (onehot) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = 8'd1;
                end else begin
                    cnt_nxt   = 8'd0;
                end
            end
            SETTLE, HOLD: begin
                if (changed) begin
                    state_nxt = onehot ? SETTLE : IDLE;
                    cnt_nxt   = onehot ? 8'd1 : 8'd0;
                end else if (state == SETTLE) begin
                    // The sample consumed this edge is the STABLE_CYCLES-th identical one.
                    if (cnt == 8'(STABLE_CYCLES - 1)) begin
                        cap       = 1'b1;
                        state_nxt = HOLD;
                        cnt_nxt   = 8'(STABLE_CYCLES);
                    end else begin
                        cnt_nxt   = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign cap_mask = cap ? en_s2 : '0;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            slot_dig <= '0;
            slot_err <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    slot_dig[4*i +: 4] <= code;
                    slot_err[i]        <= code_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            captured     <= '0;
            frame_digits <= '0;
            frame_err    <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (&captured) begin
                captured <= cap_mask;
                if (!frame_valid || frame_ready) begin
                    frame_digits <= slot_dig;
                    frame_err    <= slot_err;
                    frame_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                captured <= captured | cap_mask;
                if (frame_valid && frame_ready) frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader with NUM_DIGITS=4, STABLE_CYCLES=8.
module tb_seg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a, b, c, d, e, f, g;
    logic [3:0]  dig_en;
    logic [15:0] frame_digits;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int total = 0;
    int bad = 0;
    int ovr_seen = 0;
    int vld_seen = 0;

    seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig_en(dig_en),
        .frame_digits(frame_digits), .frame_err(frame_err),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] en, input logic [6:0] s);
        dig_en = en;
        {a, b, c, d, e, f, g} = s;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (overrun) ovr_seen++;
            if (frame_valid) vld_seen++;
        end
    endtask

    task automatic show(input logic [3:0] en, input logic [6:0] s, input int n);
        set_in(en, s);
        step(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        set_in(4'b0000, 7'b0000000);
        frame_ready = 1'b1;
        step(3);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_digits", 32'(frame_digits), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_state", 32'(dut.state), 0);
        rst_n = 1'b1;
        step(3);

        // Loopback frame 0,1,2,3
        show(4'b0001, 7'b1111110, 20);
        show(4'b0010, 7'b0110000, 20);
        show(4'b0100, 7'b1101101, 20);
        set_in(4'b1000, 7'b1111001);
        step(10);
        chk("f1_not_yet", 32'(frame_valid), 0);
        step(1);
        chk("f1_valid", 32'(frame_valid), 1);
        chk("f1_digits", 32'(frame_digits), 32'h3210);
        chk("f1_err", 32'(frame_err), 0);
        step(1);
        chk("f1_drop", 32'(frame_valid), 0);
        step(8);

        // Illegal, blank, and glitch on the completing digit
        show(4'b0001, 7'b0000001, 20);
        show(4'b0100, 7'b0000000, 20);
        show(4'b1000, 7'b1111111, 20);
        set_in(4'b0010, 7'b0110011);
        step(4);
        set_in(4'b0010, 7'b1110011);
        step(1);
        set_in(4'b0010, 7'b0110011);
        step(10);
        chk("glitch_no_early", 32'(frame_valid), 0);
        step(1);
        chk("f2_valid", 32'(frame_valid), 1);
        chk("f2_digits", 32'(frame_digits), 32'h8F4E);
        chk("f2_err", 32'(frame_err), 32'h1);
        step(1);
        chk("f2_drop", 32'(frame_valid), 0);
        step(8);

        // Backpressure then overrun
        frame_ready = 1'b0;
        ovr_seen = 0;
        show(4'b0001, 7'b1011011, 20);
        show(4'b0010, 7'b1011111, 20);
        show(4'b0100, 7'b1110000, 20);
        show(4'b1000, 7'b1111011, 20);
        chk("f3_valid", 32'(frame_valid), 1);
        chk("f3_digits", 32'(frame_digits), 32'h9765);
        chk("f3_no_ovr", 32'(ovr_seen), 0);
        show(4'b0001, 7'b1111111, 20);
        show(4'b0010, 7'b1111111, 20);
        show(4'b0100, 7'b1111111, 20);
        show(4'b1000, 7'b1111111, 20);
        chk("ovr_once", 32'(ovr_seen), 1);
        chk("f3_held_valid", 32'(frame_valid), 1);
        chk("f3_held_digits", 32'(frame_digits), 32'h9765);
        frame_ready = 1'b1;
        chk("ready_pre_edge", 32'(frame_valid), 1);
        step(1);
        chk("ready_drop", 32'(frame_valid), 0);

        // Invalid enables
        show(4'b0110, 7'b1111111, 50);
        chk("multi_en_idle", 32'(dut.state), 0);
        chk("multi_en_nocap", 32'(dut.captured), 0);
        show(4'b0000, 7'b1111111, 50);
        chk("zero_en_idle", 32'(dut.state), 0);
        set_in(4'b0100, 7'b1101101);
        step(9);
        chk("en2_not_yet", 32'(dut.captured), 0);
        step(1);
        chk("en2_cap", 32'(dut.captured), 32'b0100);

        // Reset mid-frame
        show(4'b0001, 7'b0110000, 20);
        show(4'b0010, 7'b0110000, 20);
        chk("partial_mask", 32'(dut.captured), 32'b0111);
        rst_n = 1'b0;
        #1;
        chk("arst_digits", 32'(frame_digits), 0);
        chk("arst_valid", 32'(frame_valid), 0);
        chk("arst_mask", 32'(dut.captured), 0);
        set_in(4'b1000, 7'b1111001);
        step(1);
        rst_n = 1'b1;
        vld_seen = 0;
        step(30);
        chk("post_rst_noframe", 32'(vld_seen), 0);
        chk("post_rst_mask", 32'(dut.captured), 32'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
